// File: rtl/fpu_round_pipe.sv
// Elastic two-stage IEEE rounding unit: stage 1 captures mantissa/L/G/S, stage 2 holds the rounded result.
// Optional macro ROUND_STATS_EN adds a saturating counter of inexact output transfers.
module fpu_round_pipe #(
  parameter int MAN_W = 24,
  parameter int EXT_W = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAN_W-1:0] in_mant,
  input  logic [EXT_W-1:0] in_ext,
  input  logic             in_sticky,
  input  logic             in_sign,
  input  logic [2:0]       in_rmode,
`ifdef ROUND_STATS_EN
  input  logic             stat_clr,
  output logic [15:0]      stat_inexact,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAN_W-1:0] out_mant,
  output logic             out_carry,
  output logic             out_inexact,
  output logic             out_mode_err
);

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RUP = 3'b010;
  localparam logic [2:0] RM_RDN = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam logic [MAN_W-1:0] ONE_POINT_ZERO = {1'b1, {(MAN_W-1){1'b0}}};

  function automatic logic round_inc(input logic [2:0] mode, input logic sign,
                                     input logic l, input logic g, input logic s);
    case (mode)
      RM_RNE:  return g & (l | s);
      RM_RTZ:  return 1'b0;
      RM_RUP:  return !sign & (g | s);
      RM_RDN:  return sign & (g | s);
      RM_RMM:  return g;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic mode_reserved(input logic [2:0] mode);
    return (mode > RM_RMM);
  endfunction

  // Returns {carry, mantissa}; a carry renormalises the mantissa to 1.000...
  function automatic logic [MAN_W:0] round_mant(input logic [MAN_W-1:0] mant, input logic inc);
    logic [MAN_W:0] sum;
    sum = {1'b0, mant} + {{MAN_W{1'b0}}, inc};
    if (sum[MAN_W]) return {1'b1, ONE_POINT_ZERO};
    return sum;
  endfunction

  logic             vld_p1_q, vld_p1_d;
  logic [MAN_W-1:0] mant_p1_q, mant_p1_d;
  logic             sign_p1_q, sign_p1_d;
  logic [2:0]       rmode_p1_q, rmode_p1_d;
  logic             guard_p1_q, guard_p1_d;
  logic             sticky_p1_q, sticky_p1_d;

  logic             vld_p2_q, vld_p2_d;
  logic [MAN_W-1:0] mant_p2_q, mant_p2_d;
  logic             carry_p2_q, carry_p2_d;
  logic             inexact_p2_q, inexact_p2_d;
  logic             moderr_p2_q, moderr_p2_d;

  logic             adv1, adv2;
  logic             inc_p1;
  logic [MAN_W:0]   rounded_p1;

  assign adv2     = !vld_p2_q | out_ready;
  assign adv1     = !vld_p1_q | adv2;
  assign in_ready = adv1;

  // Stage 0 -> 1: capture operand and collapse extension bits into G and S
  always_comb begin
    vld_p1_d    = vld_p1_q;
    mant_p1_d   = mant_p1_q;
    sign_p1_d   = sign_p1_q;
    rmode_p1_d  = rmode_p1_q;
    guard_p1_d  = guard_p1_q;
    sticky_p1_d = sticky_p1_q;
    if (adv1) begin
      vld_p1_d = in_valid;
      if (in_valid) begin
        mant_p1_d   = in_mant;
        sign_p1_d   = in_sign;
        rmode_p1_d  = in_rmode;
        guard_p1_d  = in_ext[EXT_W-1];
        sticky_p1_d = (|in_ext[EXT_W-2:0]) | in_sticky;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) vld_p1_q <= 1'b0;
    else     vld_p1_q <= vld_p1_d;
  end

  always_ff @(posedge CLK) begin
    mant_p1_q   <= mant_p1_d;
    sign_p1_q   <= sign_p1_d;
    rmode_p1_q  <= rmode_p1_d;
    guard_p1_q  <= guard_p1_d;
    sticky_p1_q <= sticky_p1_d;
  end

  assign inc_p1     = round_inc(rmode_p1_q, sign_p1_q, mant_p1_q[0], guard_p1_q, sticky_p1_q);
  assign rounded_p1 = round_mant(mant_p1_q, inc_p1);

  // Stage 1 -> 2: apply increment; registers drive the outputs directly
  always_comb begin
    vld_p2_d     = vld_p2_q;
    mant_p2_d    = mant_p2_q;
    carry_p2_d   = carry_p2_q;
    inexact_p2_d = inexact_p2_q;
    moderr_p2_d  = moderr_p2_q;
    if (adv2) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        mant_p2_d    = rounded_p1[MAN_W-1:0];
        carry_p2_d   = rounded_p1[MAN_W];
        inexact_p2_d = guard_p1_q | sticky_p1_q;
        moderr_p2_d  = mode_reserved(rmode_p1_q);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_p2_q     <= 1'b0;
      mant_p2_q    <= '0;
      carry_p2_q   <= 1'b0;
      inexact_p2_q <= 1'b0;
      moderr_p2_q  <= 1'b0;
    end else begin
      vld_p2_q     <= vld_p2_d;
      mant_p2_q    <= mant_p2_d;
      carry_p2_q   <= carry_p2_d;
      inexact_p2_q <= inexact_p2_d;
      moderr_p2_q  <= moderr_p2_d;
    end
  end

  assign out_valid    = vld_p2_q;
  assign out_mant     = mant_p2_q;
  assign out_carry    = carry_p2_q;
  assign out_inexact  = inexact_p2_q;
  assign out_mode_err = moderr_p2_q;

`ifdef ROUND_STATS_EN
  logic [15:0] stat_q, stat_d;

  // Clear wins over a coincident increment; count saturates at all-ones
  always_comb begin
    stat_d = stat_q;
    if (stat_clr)
      stat_d = '0;
    else if (vld_p2_q && out_ready && inexact_p2_q && (stat_q != 16'hFFFF))
      stat_d = stat_q + 16'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) stat_q <= '0;
    else     stat_q <= stat_d;
  end

  assign stat_inexact = stat_q;
`endif

endmodule

// File: tb/tb_fpu_round_pipe.sv
// Scoreboard bench for fpu_round_pipe: directed vectors, backpressure and mid-stream reset.
module tb_fpu_round_pipe;

  localparam int MAN_W = 24;
  localparam int EXT_W = 3;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [MAN_W-1:0] in_mant = '0;
  logic [EXT_W-1:0] in_ext = '0;
  logic             in_sticky = 1'b0;
  logic             in_sign = 1'b0;
  logic [2:0]       in_rmode = 3'b000;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [MAN_W-1:0] out_mant;
  logic             out_carry;
  logic             out_inexact;
  logic             out_mode_err;
`ifdef ROUND_STATS_EN
  logic             stat_clr = 1'b0;
  logic [15:0]      stat_inexact;
`endif

  fpu_round_pipe #(.MAN_W(MAN_W), .EXT_W(EXT_W)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_ext(in_ext), .in_sticky(in_sticky),
    .in_sign(in_sign), .in_rmode(in_rmode),
`ifdef ROUND_STATS_EN
    .stat_clr(stat_clr), .stat_inexact(stat_inexact),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_carry(out_carry),
    .out_inexact(out_inexact), .out_mode_err(out_mode_err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [MAN_W-1:0] mant;
    logic             carry;
    logic             inexact;
    logic             moderr;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: a transfer happens at the next rising edge when valid & ready at the falling edge
  always @(negedge CLK) begin
    if (!RST && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%h required=none", out_mant);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_mant", 32'(out_mant), 32'(e.mant));
        chk("out_carry", 32'(out_carry), 32'(e.carry));
        chk("out_inexact", 32'(out_inexact), 32'(e.inexact));
        chk("out_mode_err", 32'(out_mode_err), 32'(e.moderr));
      end
    end
  end

  task automatic send(input logic [MAN_W-1:0] m, input logic [EXT_W-1:0] x, input logic st,
                      input logic sg, input logic [2:0] rm,
                      input logic [MAN_W-1:0] em, input logic ec, input logic ex, input logic ee);
    logic acc;
    exp_t e;
    in_valid  = 1'b1;
    in_mant   = m;
    in_ext    = x;
    in_sticky = st;
    in_sign   = sg;
    in_rmode  = rm;
    acc = 1'b0;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge CLK);
      acc = in_ready;
      @(posedge CLK);
      if (acc) begin
        e = '{mant: em, carry: ec, inexact: ex, moderr: ee};
        sb.push_back(e);
      end
      #1;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (n >= 100) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  logic [MAN_W-1:0] held;
  logic             seen;

  initial begin
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_mant", 32'(out_mant), 32'd0);
    chk("rst_out_flags", 32'({out_carry, out_inexact, out_mode_err}), 32'd0);
    @(posedge CLK);
    #1 RST = 1'b0;
    #1 chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge CLK);
    #1;

    // RNE ties and sticky
    send(24'h800001, 3'b100, 1'b0, 1'b0, 3'b000, 24'h800002, 1'b0, 1'b1, 1'b0);
    send(24'h800002, 3'b100, 1'b0, 1'b0, 3'b000, 24'h800002, 1'b0, 1'b1, 1'b0);
    send(24'h800002, 3'b100, 1'b1, 1'b0, 3'b000, 24'h800003, 1'b0, 1'b1, 1'b0);
    // Directed modes
    send(24'h900000, 3'b001, 1'b0, 1'b0, 3'b010, 24'h900001, 1'b0, 1'b1, 1'b0);
    send(24'h900000, 3'b001, 1'b0, 1'b1, 3'b010, 24'h900000, 1'b0, 1'b1, 1'b0);
    send(24'h900000, 3'b001, 1'b0, 1'b1, 3'b011, 24'h900001, 1'b0, 1'b1, 1'b0);
    send(24'h900000, 3'b001, 1'b0, 1'b0, 3'b011, 24'h900000, 1'b0, 1'b1, 1'b0);
    // Mode coverage, including a reserved encoding
    send(24'hA00000, 3'b100, 1'b0, 1'b0, 3'b100, 24'hA00001, 1'b0, 1'b1, 1'b0);
    send(24'hA00000, 3'b100, 1'b0, 1'b0, 3'b001, 24'hA00000, 1'b0, 1'b1, 1'b0);
    send(24'hA00000, 3'b100, 1'b0, 1'b0, 3'b110, 24'hA00000, 1'b0, 1'b1, 1'b1);
    send(24'hA00000, 3'b100, 1'b0, 1'b0, 3'b000, 24'hA00000, 1'b0, 1'b1, 1'b0);
    // Exact inputs never round or flag inexact
    for (int m = 0; m < 5; m++)
      send(24'hA00000, 3'b000, 1'b0, 1'b1, 3'(m), 24'hA00000, 1'b0, 1'b0, 1'b0);
    send(24'hA00000, 3'b000, 1'b0, 1'b1, 3'b111, 24'hA00000, 1'b0, 1'b0, 1'b1);
    wait_drain();

    // Carry-out with latency check from an empty pipeline
    send(24'hFFFFFF, 3'b110, 1'b0, 1'b0, 3'b000, 24'h800000, 1'b1, 1'b1, 1'b0);
    @(negedge CLK);
    chk("lat_cycle1_out_valid", 32'(out_valid), 32'd0);
    @(negedge CLK);
    chk("lat_cycle2_out_valid", 32'(out_valid), 32'd1);
    wait_drain();

    // Backpressure: 5 beats, stall 3 cycles after first out_valid
    fork
      begin
        for (int i = 0; i < 5; i++)
          send(24'hC00000 + 24'(i), 3'b000, 1'b0, 1'b0, 3'b001,
               24'hC00000 + 24'(i), 1'b0, 1'b0, 1'b0);
      end
      begin
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
          @(posedge CLK);
          #1 seen = out_valid;
        end
        if (!seen) chk("bp_first_valid_timeout", 32'd0, 32'd1);
        out_ready = 1'b0;
        held = out_mant;
        for (int k = 0; k < 3; k++) begin
          @(negedge CLK);
          chk("bp_stall_valid", 32'(out_valid), 32'd1);
          chk("bp_stall_stable", 32'(out_mant), 32'(held));
          chk("bp_in_ready_low", 32'(in_ready), 32'd0);
          @(posedge CLK);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("bp_all_drained", 32'(sb.size()), 32'd0);

    // Reset with two beats in flight
    send(24'hB00001, 3'b100, 1'b0, 1'b0, 3'b000, 24'hB00002, 1'b0, 1'b1, 1'b0);
    send(24'hB00003, 3'b100, 1'b0, 1'b0, 3'b000, 24'hB00004, 1'b0, 1'b1, 1'b0);
    #1 RST = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_out_mant", 32'(out_mant), 32'd0);
    sb.delete();
    @(posedge CLK);
    #1 RST = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk("post_rst_no_stale", 32'(out_valid), 32'd0);
    end
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
`ifdef ROUND_STATS_EN
    chk("post_rst_stat", 32'(stat_inexact), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_round_pipe.md
Name: fpu_round_pipe

Overview:
- Parametrised, elastic two-stage rounding unit for the FPU datapath. Sits after the normaliser and before exponent adjust/pack.
- Takes a normalised mantissa (hidden bit + fraction), its extension bits below the LSB, a sign, and a per-operation rounding mode.
- Produces the rounded mantissa, a carry-out/renormalise indication and IEEE inexact, with valid/ready flow control.
- Supports five rounding modes, including round-to-nearest-ties-away.

Parameters:
- MAN_W, 24, mantissa width including hidden bit (24 = single, 53 = double).
- EXT_W, 3, extension bits below mantissa LSB; MSB is guard, the rest are ORed into sticky; minimum 2.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- in_mant  in  MAN_W  normalised mantissa, hidden bit at MSB.
- in_ext  in  EXT_W  bits below LSB; [EXT_W-1] = G.
- in_sticky  in  1  external sticky (T) from alignment/normalise shifts.
- in_sign  in  1  result sign.
- in_rmode  in  3  000 RNE, 001 RTZ, 010 RUP (+inf), 011 RDN (-inf), 100 RMM (ties away); 101-111 reserved.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_mant  out  MAN_W  rounded mantissa.
- out_carry  out  1  rounding overflowed mantissa; downstream increments exponent.
- out_inexact  out  1  G|S nonzero.
- out_mode_err  out  1  reserved mode was presented.

Behaviour:
- Reset: all stage valid bits cleared and all output registers set to 0, asynchronously on RST high. in_ready = 1 once RST is low. In-flight beats are discarded with no output.
- Stage 1 register captures:
  - in_mant, in_sign, in_rmode.
  - L = in_mant[0], G = in_ext[EXT_W-1].
  - S = |in_ext[EXT_W-2:0] | in_sticky.
- Stage 2 register holds the rounded result and drives all out_* signals directly from flops.
- Advance rules:
  - adv2 = !v2 | out_ready.
  - adv1 = !v1 | adv2.
  - in_ready = adv1 (combinational).
  - A beat transfers on valid & ready at each boundary.
- Latency and throughput: 2 cycles in_valid→out_valid with no stall. Throughput 1 beat/cycle. Order preserved, no drops, no duplicates.
- out_* hold stable while out_valid & !out_ready.
- Increment inc by mode:
  - RNE: G&(L|S).
  - RTZ: 0.
  - RUP: !sign&(G|S).
  - RDN: sign&(G|S).
  - RMM: G.
  - Reserved: inc = 0 (RTZ) and out_mode_err = 1; otherwise 0.
- Arithmetic: {c, sum} = in_mant + inc, at MAN_W+1 bits.
  - c = 0: out_mant = sum.
  - c = 1: out_mant = 1 << (MAN_W-1) (renormalised 1.000…), out_carry = 1.
- out_inexact = G|S, independent of mode, including RTZ and reserved modes.
- Boundaries:
  - Exact input (G=S=0) gives inc = 0 in all modes.
  - Pipeline full with out_ready low drops in_ready in the same cycle.
  - Simultaneous output drain and input accept on a full pipeline is allowed (no bubble).

Optional Feature:
- Macro: ROUND_STATS_EN.
- When defined, adds ports:
  - stat_clr  in  1  clears the counter.
  - stat_inexact  out  16  saturating count of output transfers (out_valid & out_ready) with out_inexact = 1.
- Counter behaviour:
  - Holds at 0xFFFF.
  - stat_clr has priority: a clear coincident with an increment gives 0.
  - Reset value is 0.
- When undefined, these ports and the counter are absent; all other behaviour is identical.

Test Plan (MAN_W=24, EXT_W=3, out_ready=1 unless stated):
- RNE tie-to-even:
  - mant 0x800001, ext 100, sticky 0 → out 0x800002, inexact 1.
  - mant 0x800002, ext 100 → out 0x800002, inexact 1.
- Carry: mant 0xFFFFFF, ext 110, RNE → out_mant 0x800000, out_carry 1, inexact 1, two cycles after accept.
- Directed modes: mant 0x900000, ext 001.
  - RUP sign 0 → 0x900001.
  - RUP sign 1 → 0x900000.
  - RDN sign 1 → 0x900001.
  - All three → inexact 1.
- Mode coverage: mant 0xA00000, ext 100.
  - RMM → 0xA00001.
  - RTZ → 0xA00000, inexact 1.
  - rmode 110 → 0xA00000, mode_err 1.
  - Exact input (ext 000, sticky 0) → inexact 0 for all modes.
- Backpressure: stream 5 back-to-back beats, hold out_ready low 3 cycles after the first out_valid.
  - in_ready falls once both stages are full.
  - Outputs stable while stalled.
  - All 5 results emerge in order with no loss.
- Reset mid-stream: assert RST with 2 beats in flight.
  - out_valid goes to 0 without waiting for a clock edge.
  - No stale beat appears after release.
  - With ROUND_STATS_EN, stat_inexact reads 0.
